// File: rtl/m_store_buffer_pkg.sv
// Shared types for the M-stage store buffer.
// Covers store-type encodings, the queued entry layout and the byte-lane formatting helper.
package m_store_buffer_pkg;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } st_type_e;

  // The entry holds a word address, so the byte offset does not need to be stored.
  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] pc;
  } sb_entry_t;

  typedef struct packed {
    logic        aligned;
    logic [3:0]  be;
    logic [31:0] wd;
  } lane_t;

  function automatic lane_t lane_fmt(input logic [1:0]  st_type,
                                     input logic [1:0]  addr_lo,
                                     input logic [31:0] data);
    lane_t l;
    l = '0;
    case (st_type)
      ST_SW: begin
        l.aligned = (addr_lo == 2'b00);
        l.be      = 4'b1111;
        l.wd      = data;
      end
      ST_SH: begin
        l.aligned = !addr_lo[0];
        l.be      = addr_lo[1] ? 4'b1100 : 4'b0011;
        l.wd      = {2{data[15:0]}};
      end
      ST_SB: begin
        l.aligned = 1'b1;
        l.be      = 4'b0001 << addr_lo;
        l.wd      = {4{data[7:0]}};
      end
      default: l = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/m_store_lane_fmt.sv
// Combinational store aligner that produces the byte enables, lane-replicated data and an aligned flag.
// It has zero latency and no flow control.
module m_store_lane_fmt
  import m_store_buffer_pkg::*;
(
  input  logic [1:0]  st_type_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  output logic        aligned_o
);

  lane_t lane;

  assign lane      = lane_fmt(st_type_i, st_addr_lo_i, st_data_i);
  assign be_o      = lane.be;
  assign wd_o      = lane.wd;
  assign aligned_o = lane.aligned;

endmodule

// File: rtl/m_store_buffer.sv
// FIFO store buffer that sits in front of the word-addressed DM. A store drains one cycle after it is accepted at the earliest.
// st_ready = !full, with no full-pop bypass. Pending words are reported to the hazard unit through ld_hit.
module m_store_buffer
  import m_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [1:0]       st_type,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [31:0]      st_pc,
  output logic             st_ready,
  output logic             misalign_err,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_hit,
  input  logic             drain_en,
  output logic             dm_we,
  output logic [31:0]      dm_addr,
  output logic [3:0]       dm_be,
  output logic [31:0]      dm_wd,
  output logic [31:0]      dm_pc,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t        ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;

  logic [3:0]  fmt_be;
  logic [31:0] fmt_wd;
  logic        fmt_aligned;
  logic        req, enq, pop, empty;
  sb_entry_t   head_ent;
  logic [1:0]  ld_addr_unused;

  m_store_lane_fmt u_fmt (
    .st_type_i    (st_type),
    .st_addr_lo_i (st_addr[1:0]),
    .st_data_i    (st_data),
    .be_o         (fmt_be),
    .wd_o         (fmt_wd),
    .aligned_o    (fmt_aligned)
  );

  assign empty    = (cnt_q == '0);
  assign st_ready = (cnt_q != CNT_W'(DEPTH));
  assign req      = st_valid && (st_type != ST_RSV) && st_ready;
  assign enq      = req && fmt_aligned;
  assign pop      = !empty && drain_en;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    mis_d  = req && !fmt_aligned;
    if (enq) begin
      tail_d        = tail_q + 1'b1;
      vld_d[tail_q] = 1'b1;
    end
    if (pop) begin
      head_d        = head_q + 1'b1;
      vld_d[head_q] = 1'b0;
    end
    case ({enq, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      mis_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      mis_q  <= mis_d;
    end
  end

  // The payload needs no reset because the valid bits and the empty gate mask stale contents.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_q[tail_q] <= '{addr: st_addr[31:2], be: fmt_be, wd: fmt_wd, pc: st_pc};
    end
  end

  assign head_ent     = empty ? '0 : ent_q[head_q];
  assign dm_we        = pop;
  assign dm_addr      = {head_ent.addr, 2'b00};
  assign dm_be        = head_ent.be;
  assign dm_wd        = head_ent.wd;
  assign dm_pc        = head_ent.pc;
  assign count        = cnt_q;
  assign misalign_err = mis_q;

  // The match is on the word address only. A popping head still counts as a hit.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ld_valid && vld_q[i] && (ent_q[i].addr == ld_addr[31:2])) begin
        ld_hit = 1'b1;
      end
    end
  end

  assign ld_addr_unused = ld_addr[1:0];

endmodule

// File: tb/tb_m_store_buffer.sv
// Directed bench for m_store_buffer: stores of each width, full/ordering, load hits, misalignment and reset.
module tb_m_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [1:0]  st_type;
  logic [31:0] st_addr, st_data, st_pc;
  logic        st_ready, misalign_err;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        drain_en;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wd, dm_pc;
  logic [3:0]  dm_be;
  logic [2:0]  count;

  int compared   = 0;
  int mismatched = 0;

  m_store_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .st_valid     (st_valid),
    .st_type      (st_type),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_pc        (st_pc),
    .st_ready     (st_ready),
    .misalign_err (misalign_err),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_hit       (ld_hit),
    .drain_en     (drain_en),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_be        (dm_be),
    .dm_wd        (dm_wd),
    .dm_pc        (dm_pc),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] pc);
    st_valid = 1'b1;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
    st_pc    = pc;
    tick();
    st_valid = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_type = 2'b00; st_addr = '0; st_data = '0; st_pc = '0;
    ld_valid = 1'b0; ld_addr = '0; drain_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_ld_hit", 32'(ld_hit), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    ld_valid = 1'b0;

    // A word store drains in the cycle after it is accepted.
    drain_en = 1'b1;
    store(2'b00, 32'h0000_0010, 32'h1234_5678, 32'h0000_0400);
    chk("sw_dm_we", 32'(dm_we), 32'd1);
    chk("sw_dm_addr", dm_addr, 32'h0000_0010);
    chk("sw_dm_be", 32'(dm_be), 32'hF);
    chk("sw_dm_wd", dm_wd, 32'h1234_5678);
    chk("sw_dm_pc", dm_pc, 32'h0000_0400);
    tick();
    chk("sw_count_after", 32'(count), 32'd0);
    chk("sw_dm_we_after", 32'(dm_we), 32'd0);
    chk("empty_dm_addr", dm_addr, 32'd0);

    // Byte store to lane 3.
    store(2'b10, 32'h0000_0013, 32'h0000_00AB, 32'h0000_0404);
    chk("sb_dm_be", 32'(dm_be), 32'h8);
    chk("sb_dm_wd", dm_wd, 32'hABAB_ABAB);
    chk("sb_dm_addr", dm_addr, 32'h0000_0010);
    tick();

    // Halfword store to the upper half, with data replicated.
    store(2'b01, 32'h0000_0046, 32'hDEAD_BEEF, 32'h0000_0408);
    chk("sh_dm_be", 32'(dm_be), 32'hC);
    chk("sh_dm_wd", dm_wd, 32'hBEEF_BEEF);
    chk("sh_dm_addr", dm_addr, 32'h0000_0044);
    tick();

    // Fill the buffer, then drain it in order. The pointers wrap along the way.
    drain_en = 1'b0;
    store(2'b00, 32'h0, 32'hA000_0000, 32'h100);
    store(2'b00, 32'h4, 32'hA000_0004, 32'h104);
    store(2'b00, 32'h8, 32'hA000_0008, 32'h108);
    store(2'b00, 32'hC, 32'hA000_000C, 32'h10C);
    chk("full_st_ready", 32'(st_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    store(2'b00, 32'h100, 32'hFFFF_FFFF, 32'h110);
    chk("full_reject_count", 32'(count), 32'd4);
    drain_en = 1'b1;
    #1;
    chk("drain0_addr", dm_addr, 32'h0);
    chk("drain0_wd", dm_wd, 32'hA000_0000);
    chk("drain0_no_bypass", 32'(st_ready), 32'd0);
    tick();
    chk("drain1_addr", dm_addr, 32'h4);
    chk("drain1_st_ready", 32'(st_ready), 32'd1);
    chk("drain1_count", 32'(count), 32'd3);
    tick();
    chk("drain2_addr", dm_addr, 32'h8);
    tick();
    chk("drain3_addr", dm_addr, 32'hC);
    chk("drain3_pc", dm_pc, 32'h10C);
    tick();
    chk("drained_count", 32'(count), 32'd0);
    chk("drained_dm_we", 32'(dm_we), 32'd0);

    // Load hazard against a pending store word.
    drain_en = 1'b0;
    store(2'b00, 32'h20, 32'h5555_AAAA, 32'h200);
    ld_valid = 1'b1; ld_addr = 32'h22; #1;
    chk("ld_hit_same_word", 32'(ld_hit), 32'd1);
    ld_addr = 32'h24; #1;
    chk("ld_hit_next_word", 32'(ld_hit), 32'd0);
    ld_valid = 1'b0; ld_addr = 32'h20; #1;
    chk("ld_hit_no_valid", 32'(ld_hit), 32'd0);

    // Misaligned stores and the reserved type are dropped.
    tick();
    store(2'b01, 32'h11, 32'h1111_1111, 32'h204);
    chk("mis_sh_err", 32'(misalign_err), 32'd1);
    chk("mis_sh_count", 32'(count), 32'd1);
    chk("mis_sh_dm_we", 32'(dm_we), 32'd0);
    tick();
    chk("mis_sh_err_clear", 32'(misalign_err), 32'd0);
    store(2'b00, 32'h12, 32'h2222_2222, 32'h208);
    chk("mis_sw_err", 32'(misalign_err), 32'd1);
    chk("mis_sw_count", 32'(count), 32'd1);
    tick();
    chk("mis_sw_err_clear", 32'(misalign_err), 32'd0);
    store(2'b11, 32'h40, 32'h3333_3333, 32'h20C);
    chk("rsv_count", 32'(count), 32'd1);
    chk("rsv_err", 32'(misalign_err), 32'd0);

    // Reset in the middle of operation discards all pending entries.
    store(2'b00, 32'h30, 32'h4444_4444, 32'h210);
    store(2'b10, 32'h35, 32'h0000_0055, 32'h214);
    chk("pre_rst_count", 32'(count), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drain_en = 1'b1;
    ld_valid = 1'b1; ld_addr = 32'h20; #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_dm_we", 32'(dm_we), 32'd0);
    chk("midrst_st_ready", 32'(st_ready), 32'd1);
    chk("midrst_ld_hit_20", 32'(ld_hit), 32'd0);
    ld_addr = 32'h34; #1;
    chk("midrst_ld_hit_34", 32'(ld_hit), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
